// File: rtl/mul_acc_sequencer.sv
// Iterative 32x32 multiply / multiply-accumulate: one shift-and-add step per clock,
// one shared 32-bit adder, low-word result with N/Z flags and busy/done handshake.

module Adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};
endmodule

module mul_acc_sequencer #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mla,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] acc,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        flag_n,
    output logic        flag_z
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] m_reg, q_reg, p_reg;
    logic [31:0] add_sum, p_nx;
    logic [4:0]  cnt;
    logic        run_last;
    logic        adder_c_out_unused;

    Adder_32 u_adder (
        .a     (p_reg),
        .b     (m_reg),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (adder_c_out_unused)
    );

    assign p_nx     = q_reg[0] ? add_sum : p_reg;
    assign run_last = (cnt == 5'd31) || (EARLY_EXIT && (q_reg[31:1] == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !flush) state_nx = RUN;
            RUN: begin
                if (flush)         state_nx = IDLE;
                else if (run_last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // The final step's addition lands in result on the same edge that leaves RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg  <= '0;
            q_reg  <= '0;
            p_reg  <= '0;
            cnt    <= '0;
            result <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        m_reg <= a;
                        q_reg <= b;
                        p_reg <= mla ? acc : '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        p_reg <= p_nx;
                        m_reg <= m_reg << 1;
                        q_reg <= q_reg >> 1;
                        cnt   <= cnt + 5'd1;
                        if (run_last) begin
                            result <= p_nx;
                            flag_n <= p_nx[31];
                            flag_z <= (p_nx == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
